// File: rtl/vga_line_pkg.sv
// Shared types and constants for the scan-doubler line RAM scheduler.
//   DEF_DATA_W  : default pixel width (RGB555)
//   LINE_AW     : line RAM address width, {bank, column}
//   COL_W       : pixel column width
//   SYNC_CNT_W  : width of the frame-sync delay counter
//   sync_state_t: frame-sync FSM state encoding
//   wr_entry_t  : one queued PPU pixel write at the default pixel width
package vga_line_pkg;

  localparam int unsigned DEF_DATA_W = 15;
  localparam int unsigned LINE_AW    = 9;
  localparam int unsigned COL_W      = 8;
  localparam int unsigned SYNC_CNT_W = 16;

  typedef logic [1:0] sync_state_t;
  localparam sync_state_t SyncIdle  = 2'd0;
  localparam sync_state_t SyncArmed = 2'd1;
  localparam sync_state_t SyncFire  = 2'd2;

  typedef struct packed {
    logic                  bank;
    logic [COL_W-1:0]      x;
    logic [DEF_DATA_W-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/vga_line_scheduler_if.sv
// Single-port line RAM bus between the scheduler and the RAM macro.
//   ram_addr  : {bank, column}
//   ram_we    : write enable
//   ram_wdata : write data
//   ram_rdata : registered read data, one cycle after the address
// master = scheduler side, slave = RAM side.
interface vga_line_scheduler_if import vga_line_pkg::*; #(
  parameter int unsigned DATA_W = DEF_DATA_W
);
  logic [LINE_AW-1:0] ram_addr;
  logic               ram_we;
  logic [DATA_W-1:0]  ram_wdata;
  logic [DATA_W-1:0]  ram_rdata;

  modport master (output ram_addr, output ram_we, output ram_wdata, input ram_rdata);
  modport slave  (input ram_addr, input ram_we, input ram_wdata, output ram_rdata);
endinterface

// File: rtl/line_wr_fifo.sv
// Small synchronous FIFO holding PPU pixel writes until a RAM write slot.
//   clk, reset_n : clock, synchronous active-low reset
//   push         : write request (dropped when full with no pop in the same cycle)
//   push_data    : entry to enqueue
//   pop          : dequeue request (ignored when empty)
//   head         : entry at the head of the queue
//   empty        : no entries queued
//   overflow     : sticky, registered; set when a push was dropped
module line_wr_fifo import vga_line_pkg::*; #(
  parameter type         entry_t    = wr_entry_t,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head,
  output logic   empty,
  output logic   overflow
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  entry_t          mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic            overflow_q;
  logic            full, do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CntW'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  // A same-cycle pop frees a slot, so a push is accepted even when full.
  assign do_push = push && (!full || do_pop);

  assign head     = mem_q[rd_ptr_q];
  assign overflow = overflow_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CntW'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - CntW'(1);
      if (push && !do_push) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/vga_line_scheduler.sv
// Scan-doubler line RAM scheduler between the NES PPU pixel writer and the
// VGA driver. Even VGA half-pixels read the RAM, odd half-pixels drain the
// PPU write FIFO. Also emits the frame sync pulse a fixed delay after each
// PPU frame start.
//   clk, reset_n     : clock, synchronous active-low reset
//   ppu_we/bank/x/data : PPU pixel write (no back-pressure)
//   ppu_frame_start  : one-cycle pulse at NES frame start
//   vga_next_x       : [9]=bank, [8:1]=column, [0]=half-pixel
//   vga_pixel        : pixel for the current cycle (2 cycles after vga_next_x)
//   vga_sync         : registered one-cycle frame sync
//   ram              : line RAM bus (master side)
//   stat_overflow    : sticky, a PPU write was dropped
module vga_line_scheduler import vga_line_pkg::*; #(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SYNC_DELAY = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ppu_we,
  input  logic                ppu_bank,
  input  logic [COL_W-1:0]    ppu_x,
  input  logic [DATA_W-1:0]   ppu_data,
  input  logic                ppu_frame_start,
  input  logic [9:0]          vga_next_x,
  output logic [DATA_W-1:0]   vga_pixel,
  output logic                vga_sync,
  vga_line_scheduler_if.master ram,
  output logic                stat_overflow
);

  typedef struct packed {
    logic             bank;
    logic [COL_W-1:0] x;
    logic [DATA_W-1:0] data;
  } line_wr_t;

  localparam logic [SYNC_CNT_W-1:0] SyncReload = SYNC_CNT_W'(SYNC_DELAY - 1);

  line_wr_t wr_in, wr_head;
  logic     fifo_empty, slot_odd, pop;

  logic [LINE_AW-1:0] ram_addr_d, ram_addr_q;
  logic [DATA_W-1:0]  ram_wdata_d, ram_wdata_q;
  logic               ram_we_d, ram_we_q;
  logic               rd_pend_d, rd_pend_q, rd_pend_dly_q;
  logic [DATA_W-1:0]  pixel_hold_q;

  sync_state_t             state_d, state_q;
  logic [SYNC_CNT_W-1:0]   cnt_d, cnt_q;
  logic                    sync_d, sync_q;

  assign wr_in    = '{bank: ppu_bank, x: ppu_x, data: ppu_data};
  assign slot_odd = vga_next_x[0];
  assign pop      = slot_odd && !fifo_empty;

  line_wr_fifo #(
    .entry_t    (line_wr_t),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (ppu_we),
    .push_data (wr_in),
    .pop       (pop),
    .head      (wr_head),
    .empty     (fifo_empty),
    .overflow  (stat_overflow)
  );

  // Slot selection: even half-pixel always reads, odd drains one write.
  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    rd_pend_d   = 1'b0;
    if (!slot_odd) begin
      ram_addr_d = {vga_next_x[9], vga_next_x[8:1]};
      rd_pend_d  = 1'b1;
    end else if (pop) begin
      ram_addr_d  = {wr_head.bank, wr_head.x};
      ram_wdata_d = wr_head.data;
      ram_we_d    = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      SyncIdle: begin
        if (ppu_frame_start) begin
          state_d = SyncArmed;
          cnt_d   = SyncReload;
        end
      end
      SyncArmed: begin
        // A new frame start restarts the delay rather than queueing a second pulse.
        if (ppu_frame_start)   cnt_d   = SyncReload;
        else if (cnt_q == '0)  state_d = SyncFire;
        else                   cnt_d   = cnt_q - SYNC_CNT_W'(1);
      end
      SyncFire: begin
        if (ppu_frame_start) begin
          state_d = SyncArmed;
          cnt_d   = SyncReload;
        end else begin
          state_d = SyncIdle;
        end
      end
      default: state_d = SyncIdle;
    endcase
    sync_d = (state_d == SyncFire);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      ram_we_q      <= 1'b0;
      rd_pend_q     <= 1'b0;
      rd_pend_dly_q <= 1'b0;
      pixel_hold_q  <= '0;
      state_q       <= SyncIdle;
      cnt_q         <= '0;
      sync_q        <= 1'b0;
    end else begin
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      ram_we_q      <= ram_we_d;
      rd_pend_q     <= rd_pend_d;
      // Aligns with the RAM's one-cycle read latency.
      rd_pend_dly_q <= rd_pend_q;
      if (rd_pend_dly_q) pixel_hold_q <= ram.ram_rdata;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sync_q        <= sync_d;
    end
  end

  assign ram.ram_addr  = ram_addr_q;
  assign ram.ram_we    = ram_we_q;
  assign ram.ram_wdata = ram_wdata_q;

  // Fresh read word on the even half, held copy on the odd half.
  assign vga_pixel = rd_pend_dly_q ? ram.ram_rdata : pixel_hold_q;
  assign vga_sync  = sync_q;

endmodule

// File: tb/tb_vga_line_scheduler.sv
module tb_vga_line_scheduler;
  import vga_line_pkg::*;

  localparam int unsigned DW    = 15;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned SDLY  = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          ppu_we, ppu_bank, ppu_frame_start;
  logic [7:0]    ppu_x;
  logic [DW-1:0] ppu_data;
  logic [9:0]    vga_next_x;
  logic [DW-1:0] vga_pixel;
  logic          vga_sync, stat_overflow;

  always #5 clk = ~clk;

  vga_line_scheduler_if #(.DATA_W(DW)) ram_if ();

  vga_line_scheduler #(
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH),
    .SYNC_DELAY (SDLY)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .ppu_we          (ppu_we),
    .ppu_bank        (ppu_bank),
    .ppu_x           (ppu_x),
    .ppu_data        (ppu_data),
    .ppu_frame_start (ppu_frame_start),
    .vga_next_x      (vga_next_x),
    .vga_pixel       (vga_pixel),
    .vga_sync        (vga_sync),
    .ram             (ram_if.master),
    .stat_overflow   (stat_overflow)
  );

  int total = 0;
  int bad   = 0;

  function automatic logic [DW-1:0] pat(input int a);
    return DW'(a * 37 + 11);
  endfunction

  // Line RAM model: registered read, preloaded with a known pattern.
  logic [DW-1:0] tb_mem [512];
  bit            mem_init = 1'b0;
  always @(posedge clk) begin
    logic [DW-1:0] rd;
    if (!mem_init) begin
      for (int i = 0; i < 512; i++) tb_mem[i] = pat(i);
      mem_init = 1'b1;
    end
    rd = tb_mem[ram_if.ram_addr];
    if (ram_if.ram_we) tb_mem[ram_if.ram_addr] = ram_if.ram_wdata;
    ram_if.ram_rdata <= rd;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard state.
  typedef struct packed {
    logic [8:0]    addr;
    logic [DW-1:0] data;
  } wr_t;
  typedef struct packed {
    logic          chk;
    logic [DW-1:0] val;
  } pix_t;

  wr_t           exp_wr[$];
  pix_t          exp_pix[$];
  logic [DW-1:0] ref_wr [int];
  bit            pix_chk = 1'b0;
  int            edge_n = 0;
  int            fire_edge = -1;
  int            m_cnt = 0;
  bit            m_ovf = 1'b0;
  int            sync_pulses = 0;
  bit            slot_vld = 1'b0;
  bit            slot_odd_s = 1'b0;
  logic [8:0]    slot_addr_s = '0;

  function automatic logic [DW-1:0] exp_word(input logic [8:0] a);
    if (ref_wr.exists(int'(a))) return ref_wr[int'(a)];
    return pat(int'(a));
  endfunction

  // Reference model, updated from inputs sampled at each active edge.
  always @(posedge clk) begin
    bit m_pop;
    edge_n++;
    slot_vld    = reset_n;
    slot_odd_s  = vga_next_x[0];
    slot_addr_s = {vga_next_x[9], vga_next_x[8:1]};
    if (!reset_n) begin
      m_cnt     = 0;
      m_ovf     = 1'b0;
      fire_edge = -1;
      exp_wr.delete();
    end else begin
      m_pop = vga_next_x[0] && (m_cnt > 0);
      if (ppu_we) begin
        if (m_cnt < int'(DEPTH) || m_pop) begin
          exp_wr.push_back('{addr: {ppu_bank, ppu_x}, data: ppu_data});
          ref_wr[int'({ppu_bank, ppu_x})] = ppu_data;
          m_cnt++;
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (m_pop) m_cnt--;
      if (ppu_frame_start) fire_edge = edge_n + int'(SDLY);
    end
    exp_pix.push_back('{chk: pix_chk && reset_n, val: exp_word(slot_addr_s)});
  end

  // Output checks, away from the active edge.
  always @(negedge clk) begin
    pix_t p;
    wr_t  w;
    if (exp_pix.size() >= 2) begin
      p = exp_pix.pop_front();
      if (p.chk) chk("pixel", vga_pixel, p.val);
    end
    if (!slot_vld) begin
      chk("rst_ram_we", ram_if.ram_we, 0);
      chk("rst_ram_addr", ram_if.ram_addr, 0);
      chk("rst_ram_wdata", ram_if.ram_wdata, 0);
      chk("rst_pixel", vga_pixel, 0);
    end else if (!slot_odd_s) begin
      chk("rd_slot_we", ram_if.ram_we, 0);
      chk("rd_slot_addr", ram_if.ram_addr, slot_addr_s);
    end else if (ram_if.ram_we) begin
      if (exp_wr.size() == 0) begin
        chk("wr_spurious", ram_if.ram_we, 0);
      end else begin
        w = exp_wr.pop_front();
        chk("wr_addr", ram_if.ram_addr, w.addr);
        chk("wr_data", ram_if.ram_wdata, w.data);
      end
    end
    chk("sync", vga_sync, (slot_vld && edge_n == fire_edge) ? 1 : 0);
    chk("overflow", stat_overflow, m_ovf);
    if (vga_sync) sync_pulses++;
  end

  task automatic drain(input string tag);
    int n = 0;
    ppu_we = 1'b0;
    while (exp_wr.size() != 0 && n < 40) begin
      vga_next_x = {vga_next_x[9:1], ~vga_next_x[0]};
      tick();
      n++;
    end
    tick();
    chk(tag, exp_wr.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    reset_n = 1'b0; ppu_we = 1'b1; ppu_bank = 1'b0; ppu_x = '0; ppu_data = '0;
    ppu_frame_start = 1'b0; vga_next_x = '0;
    repeat (3) tick();
    reset_n = 1'b1; ppu_we = 1'b0;
    // Odd slots right after reset must not write anything.
    for (int i = 0; i < 6; i++) begin
      vga_next_x = 10'(i);
      tick();
    end
    chk("post_rst_ovf", stat_overflow, 0);

    // Single write, then read it back through the doubling path.
    vga_next_x = 10'h000; ppu_we = 1'b1; ppu_bank = 1'b1; ppu_x = 8'h05; ppu_data = 15'h7C1F;
    tick();
    ppu_we = 1'b0; vga_next_x = 10'h001;
    tick();
    vga_next_x = 10'h002;
    tick();
    drain("drain_single");
    vga_next_x = 10'h200; pix_chk = 1'b1;
    for (int i = 0; i < 16; i++) begin
      vga_next_x = 10'h200 + 10'(i);
      tick();
    end
    pix_chk = 1'b0;

    // Back-to-back writes with toggling slots.
    for (int i = 0; i < 4; i++) begin
      vga_next_x = 10'(i); ppu_we = 1'b1; ppu_bank = 1'b0; ppu_x = 8'(i);
      ppu_data = 15'h1110 + 15'(i);
      tick();
    end
    drain("drain_b2b");
    pix_chk = 1'b1;
    for (int i = 0; i < 8; i++) begin
      vga_next_x = 10'(i);
      tick();
    end
    pix_chk = 1'b0;

    // Overflow with writes slots starved.
    vga_next_x = 10'h000;
    for (int i = 0; i < 6; i++) begin
      ppu_we = 1'b1; ppu_bank = 1'b1; ppu_x = 8'h10 + 8'(i); ppu_data = 15'h2220 + 15'(i);
      tick();
    end
    ppu_we = 1'b0;
    tick();
    chk("ovf_set", stat_overflow, 1);
    drain("drain_ovf");
    chk("ovf_sticky", stat_overflow, 1);
    pix_chk = 1'b1;
    for (int i = 0; i < 12; i++) begin
      vga_next_x = 10'h220 + 10'(i);
      tick();
    end
    pix_chk = 1'b0;
    repeat (3) tick();

    // Sync: reload after 10 cycles gives a single pulse.
    p0 = sync_pulses;
    ppu_frame_start = 1'b1; tick(); ppu_frame_start = 1'b0;
    repeat (9) tick();
    ppu_frame_start = 1'b1; tick(); ppu_frame_start = 1'b0;
    repeat (30) tick();
    chk("sync_reload_pulses", sync_pulses - p0, 1);

    // Frame start landing in the FIRE cycle re-arms.
    p0 = sync_pulses;
    ppu_frame_start = 1'b1; tick(); ppu_frame_start = 1'b0;
    repeat (16) tick();
    chk("sync_fire_cycle", vga_sync, 1);
    ppu_frame_start = 1'b1; tick(); ppu_frame_start = 1'b0;
    repeat (30) tick();
    chk("sync_fire_rearm_pulses", sync_pulses - p0, 2);

    // Reset mid-operation discards queued writes and the armed sync.
    p0 = sync_pulses;
    vga_next_x = 10'h000;
    for (int i = 0; i < 3; i++) begin
      ppu_we = 1'b1; ppu_bank = 1'b0; ppu_x = 8'h30 + 8'(i); ppu_data = 15'h3330 + 15'(i);
      ppu_frame_start = (i == 2);
      tick();
    end
    ppu_we = 1'b0; ppu_frame_start = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      vga_next_x = 10'(i);
      tick();
    end
    chk("rst_mid_no_sync", sync_pulses - p0, 0);
    chk("rst_mid_ovf_clr", stat_overflow, 0);
    chk("rst_mid_no_wr", exp_wr.size(), 0);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_line_scheduler.md
Name: vga_line_scheduler

Overview:
- Owns the single-port scan-doubler line RAM (2 banks x 256 entries) between the NES PPU pixel writer and the VGA driver pixel reader.
- Time-slices RAM access:
  - even VGA half-pixels are reserved for reads;
  - odd half-pixels drain a small write FIFO fed by the PPU.
- Generates the one-cycle frame `sync` pulse to the VGA driver, a programmable delay after each PPU frame start.

Parameters:
- DATA_W, 15, pixel width (RGB555), matches VGA driver `pixel` input
- FIFO_DEPTH, 4, PPU write FIFO entries (power of two, >=2)
- SYNC_DELAY, 16, cycles from ppu_frame_start to vga_sync pulse (>=1, <=65535)

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- ppu_we  in  1  PPU pixel write strobe (no back-pressure)
- ppu_bank  in  1  line bank being written (PPU scanline bit 0)
- ppu_x  in  8  pixel column 0..255
- ppu_data  in  DATA_W  pixel colour
- ppu_frame_start  in  1  one-cycle pulse at start of NES frame
- vga_next_x  in  10  VGA driver next_pixel_x: [9]=bank, [8:1]=column, [0]=half-pixel
- vga_pixel  out  DATA_W  pixel for current cycle, to VGA driver
- vga_sync  out  1  one-cycle frame sync to VGA driver
- ram_addr  out  9  {bank, column}
- ram_we  out  1  RAM write enable
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, registered, 1-cycle latency
- stat_overflow  out  1  sticky: a PPU write was dropped

Behaviour:
- Reset (reset_n=0 at clk edge):
  - FIFO empty; pixel_hold=0; rd_pend=0.
  - Sync FSM in IDLE with counter=0.
  - Outputs: vga_pixel=0, vga_sync=0, ram_we=0, ram_addr=0, ram_wdata=0, stat_overflow=0.
  - Reset mid-operation discards queued writes and any armed sync.
- Slot selection (combinational from vga_next_x[0], registered RAM controls):
  - Even slot (vga_next_x[0]=0), read:
    - ram_addr<={vga_next_x[9], vga_next_x[8:1]}, ram_we<=0, rd_pend<=1.
  - Odd slot, write:
    - If FIFO non-empty: pop head; ram_addr<={bank,x}; ram_wdata<=data; ram_we<=1.
    - Else ram_we<=0.
    - rd_pend<=0.
  - Writes never occur in an even slot; a read is never skipped.
- Read return:
  - ram_rdata is valid in the cycle after the read slot has been presented to the RAM.
  - vga_pixel = rd_pend_d ? ram_rdata : pixel_hold, where rd_pend_d is rd_pend delayed one cycle to align with RAM latency.
  - pixel_hold captures ram_rdata whenever rd_pend_d=1.
  - Net effect: each RAM word is presented for both half-pixels of a doubled pixel.
  - Total latency, vga_next_x to vga_pixel: 2 cycles, matching the driver's "pixel for current cycle" contract when the driver is fed vga_next_x.
- FIFO:
  - Push on ppu_we when not full.
  - Push and pop in the same cycle are allowed: count is unchanged, and push is allowed even when full in that cycle, because a pop frees the slot.
  - ppu_we while full with no pop: entry dropped, stat_overflow<=1; cleared only by reset.
  - Pointers wrap modulo FIFO_DEPTH.
  - Sustained PPU rate must be <=1 write per 2 cycles.
- Sync FSM:
  - IDLE: on ppu_frame_start, counter<=SYNC_DELAY-1, go to ARMED.
  - ARMED:
    - Counter decrements each cycle.
    - ppu_frame_start while ARMED reloads counter to SYNC_DELAY-1; the pulse is not duplicated.
    - At counter=0 go to FIRE.
  - FIRE: vga_sync=1 for exactly this cycle, then IDLE.
  - A frame_start arriving in the FIRE cycle goes to ARMED with a reload.
  - vga_sync is registered; the pulse appears SYNC_DELAY+1 cycles after the frame_start edge.
- vga_next_x[0] toggles every cycle in normal operation. If it holds (e.g. during the driver's sync h-reset), the slot type simply repeats: consecutive reads or consecutive write-slots. This is legal.

Decomposition:
- Package vga_line_pkg:
  - DATA_W default, LINE_AW=9, COL_W=8;
  - sync_state_t enum {IDLE, ARMED, FIRE};
  - fifo entry struct {bank, x[7:0], data}.
- Sub-module line_wr_fifo: synchronous FIFO with push/pop/full/empty/overflow. Its outputs are registered where the top-level spec requires it.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with ppu_we=1 → ram_we=0, vga_pixel=0, vga_sync=0, stat_overflow=0; FIFO empty after release.
- Write then read: ppu_we with bank=1, x=0x05, data=0x7C1F, then vga_next_x sweeps to 0x20A/0x20B → ram write to 0x105 in an odd slot. vga_pixel=0x7C1F for the two cycles aligned to 0x20A and 0x20B.
- Slot discipline: 4 back-to-back ppu_we with vga_next_x toggling from even → writes appear only in cycles with registered odd slot, one per 2 cycles. Addresses 0x000..0x003 in order; no read skipped.
- Overflow: FIFO_DEPTH=4; 6 consecutive ppu_we while vga_next_x[0] held 0 → first 4 stored, 5th and 6th dropped, stat_overflow=1 and stays 1 after the FIFO drains.
- Sync timing: SYNC_DELAY=16, ppu_frame_start at cycle 100 → vga_sync=1 only at cycle 117. Second frame_start at cycle 110 → single pulse at cycle 127.
- Reset mid-operation: 3 FIFO entries queued and FSM ARMED, then reset_n=0 for 1 cycle → no subsequent writes and no vga_sync pulse; state IDLE.
